square_wave_period_detector: RTL and testbench
==============================================

Name: square_wave_period_detector

Overview:
- Receive-side counterpart to the discrete square-wave oscillators.
- Takes a signed 16-bit audio-rate signal (e.g. an oscillator output after slew limiting), squares it up with a Schmitt trigger, and measures period and high time in system clock cycles.
- Used by the discrete chain to gate and clock downstream logic (counters, latches) from an analog-modelled oscillator, and as a bench/monitor element for oscillator frequency.

Parameters:
- HIGH_THRESHOLD, 10923: signed 16-bit level; level goes 1 when in >= this (2/3 of full 5 V scale, 16384).
- LOW_THRESHOLD, 5461: signed 16-bit level; level goes 0 when in <= this. Must be < HIGH_THRESHOLD; elaboration error otherwise.
- MAX_PERIOD_CYCLES, 50000000: clk cycles without a rising transition before loss of lock (1 s at 50 MHz).
- COUNT_WIDTH, 32: width of the internal counters and measurement outputs. Must hold MAX_PERIOD_CYCLES.

Ports:
- clk, input, 1: system clock.
- I_RST, input, 1: synchronous, active-high reset.
- audio_clk_en, input, 1: sample strobe; in is evaluated only on cycles where this is 1.
- in, input, 16 signed: analog-modelled input sample.
- level, output, 1: Schmitt-trigger digital level.
- period_cycles, output, COUNT_WIDTH: last measured period, in clk cycles.
- high_cycles, output, COUNT_WIDTH: high time of the same period, in clk cycles.
- measurement_valid, output, 1: one-cycle pulse when period_cycles and high_cycles update.
- locked, output, 1: 1 while measurements are current.
- timeout, output, 1: one-cycle pulse on loss of lock.

Behaviour:
- Reset (sync, I_RST=1 at a clk edge):
  - level=0, period_cycles=0, high_cycles=0.
  - measurement_valid=0, locked=0, timeout=0.
  - State=IDLE; counters cleared.
  - Reset mid-measurement discards partial counts; no valid or timeout pulse is emitted.
- Schmitt trigger, evaluated on audio_clk_en=1 cycles only:
  - next_level=1 if in >= HIGH_THRESHOLD.
  - next_level=0 if in <= LOW_THRESHOLD.
  - Otherwise next_level=level (hold).
  - Comparisons are signed.
  - When audio_clk_en=0, level holds.
- Transitions:
  - rise = (next_level=1 and level=0); fall = (next_level=0 and level=1).
  - Both are computed combinationally in the strobe cycle and acted on at the same clk edge that registers level.
- cyc counter: clears on every rise edge, otherwise increments each clk, saturating at MAX_PERIOD_CYCLES.
- hi counter: captures the cyc value +1 at the fall edge.
- States:
  - IDLE: waits for rise. On rise: cyc<=0, go HIGH. Falls are ignored. No timeout in IDLE.
  - HIGH: on fall, latch high count = cyc+1, go LOW.
  - LOW: on rise, period_cycles<=cyc+1, high_cycles<=latched high count, measurement_valid<=1 for one cycle, locked<=1, cyc<=0, go HIGH.
- Result: period_cycles is the number of clk edges between two consecutive rising transitions; high_cycles is the number between the rise and the following fall. Both are multiples of the strobe spacing when the strobe is periodic.
- Timeout, in HIGH or LOW:
  - Trigger: cyc+1 reaches MAX_PERIOD_CYCLES with no rise on that edge.
  - Action: timeout=1 for one cycle, locked<=0, period_cycles<=0, high_cycles<=0, state<=IDLE.
  - A rise on the same edge as the timeout condition takes priority: it is a measurement, not a timeout.
  - level is not affected by a timeout.
- Output stability:
  - period_cycles and high_cycles change only on measurement_valid, timeout or reset.
  - Outputs are registered: measurement_valid rises one clk after the sample edge that caused the rise.
- First period after reset or timeout produces no measurement; the earliest valid is at the second rise.

Test Plan:
- Hysteresis: audio_clk_en=1 every cycle, level=0, in=8000 for 50 cycles -> level stays 0.
  - Then in=11000 -> level=1 next edge.
  - Then in=8000 -> level stays 1.
  - Then in=5461 -> level=0.
- Basic measurement: audio_clk_en=1 every cycle; in alternates 16384 for 100 cycles and 0 for 100 cycles, 3 periods.
  - First valid at the second rise: period_cycles=200, high_cycles=100, locked=1.
  - measurement_valid is exactly one cycle wide, repeating every 200 cycles.
- Strobed input: audio_clk_en every 4th cycle; in is 16384 for 25 strobes and 0 for 75 strobes.
  - Response: period_cycles=400, high_cycles=100.
  - Input changes between strobes have no effect.
- Timeout: MAX_PERIOD_CYCLES=1000; lock with a 200/100 wave, then hold in=0.
  - Timeout pulse exactly 1000 cycles after the last rise: locked=0, period_cycles=0, high_cycles=0, state IDLE.
  - Restarting the wave gives its next valid only at the second rise.
- Reset mid-operation: assert I_RST for 1 cycle while in LOW with locked=1.
  - All outputs are 0 next cycle, with no valid or timeout pulse.
  - Continuing the 200/100 wave re-locks with a correct measurement after two rises.
- Simultaneous rise and timeout: MAX_PERIOD_CYCLES=200 with a 200-cycle wave.
  - Response: rise wins, measurement_valid=1, period_cycles=200, timeout stays 0.

Source files
------------

// File: rtl/square_wave_period_detector.sv
// Schmitt-trigger squaring of a signed audio-rate sample stream, measuring period
// and high time in clk cycles between consecutive rising transitions, with loss-of-lock.
module square_wave_period_detector #(
    parameter logic signed [15:0] HIGH_THRESHOLD    = 16'sd10923,
    parameter logic signed [15:0] LOW_THRESHOLD     = 16'sd5461,
    parameter int unsigned        MAX_PERIOD_CYCLES = 50000000,
    parameter int unsigned        COUNT_WIDTH       = 32
) (
    input  logic                   clk,
    input  logic                   I_RST,
    input  logic                   audio_clk_en,
    input  logic signed [15:0]     in,
    output logic                   level,
    output logic [COUNT_WIDTH-1:0] period_cycles,
    output logic [COUNT_WIDTH-1:0] high_cycles,
    output logic                   measurement_valid,
    output logic                   locked,
    output logic                   timeout
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HIGH = 2'd1;
    localparam logic [1:0] ST_LOW  = 2'd2;

    localparam logic [COUNT_WIDTH-1:0] MAX_CNT = COUNT_WIDTH'(MAX_PERIOD_CYCLES);
    localparam logic [COUNT_WIDTH-1:0] ONE     = COUNT_WIDTH'(1);

    generate
        if (LOW_THRESHOLD >= HIGH_THRESHOLD) begin : g_bad_thresholds
            $error("LOW_THRESHOLD must be strictly below HIGH_THRESHOLD");
        end
        if (64'(MAX_PERIOD_CYCLES) >= (64'd1 << COUNT_WIDTH)) begin : g_bad_width
            $error("COUNT_WIDTH too narrow to hold MAX_PERIOD_CYCLES");
        end
    endgenerate

    logic [1:0]             state;
    logic [1:0]             state_nxt;
    logic [COUNT_WIDTH-1:0] cyc;
    logic [COUNT_WIDTH-1:0] cyc_nxt;
    logic [COUNT_WIDTH-1:0] cyc_inc;
    logic [COUNT_WIDTH-1:0] hi_lat;
    logic [COUNT_WIDTH-1:0] hi_lat_nxt;
    logic [COUNT_WIDTH-1:0] period_nxt;
    logic [COUNT_WIDTH-1:0] high_nxt;
    logic                   level_nxt;
    logic                   valid_nxt;
    logic                   locked_nxt;
    logic                   timeout_nxt;
    logic                   rise;
    logic                   fall;
    logic                   limit_hit;

    // Hysteresis: only a strobed sample outside the band can move the level
    always_comb begin
        level_nxt = level;
        if (audio_clk_en) begin
            if (in >= HIGH_THRESHOLD) begin
                level_nxt = 1'b1;
            end else if (in <= LOW_THRESHOLD) begin
                level_nxt = 1'b0;
            end
        end
    end

    assign rise      = level_nxt & ~level;
    assign fall      = ~level_nxt & level;
    assign cyc_inc   = cyc + ONE;
    assign limit_hit = (cyc_inc == MAX_CNT);

    // Next-state and registered-output values; a rise outranks a coincident timeout
    always_comb begin
        state_nxt   = state;
        hi_lat_nxt  = hi_lat;
        period_nxt  = period_cycles;
        high_nxt    = high_cycles;
        valid_nxt   = 1'b0;
        locked_nxt  = locked;
        timeout_nxt = 1'b0;
        cyc_nxt     = (cyc == MAX_CNT) ? cyc : cyc_inc;
        if (rise) begin
            cyc_nxt = '0;
        end
        case (state)
            ST_IDLE: begin
                if (rise) begin
                    state_nxt = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (fall) begin
                    hi_lat_nxt = cyc_inc;
                    state_nxt  = ST_LOW;
                end
            end
            ST_LOW: begin
                if (rise) begin
                    period_nxt = cyc_inc;
                    high_nxt   = hi_lat;
                    valid_nxt  = 1'b1;
                    locked_nxt = 1'b1;
                    state_nxt  = ST_HIGH;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if ((state == ST_HIGH || state == ST_LOW) && !rise && limit_hit) begin
            timeout_nxt = 1'b1;
            locked_nxt  = 1'b0;
            period_nxt  = '0;
            high_nxt    = '0;
            state_nxt   = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (I_RST) begin
            state             <= ST_IDLE;
            cyc               <= '0;
            hi_lat            <= '0;
            level             <= 1'b0;
            period_cycles     <= '0;
            high_cycles       <= '0;
            measurement_valid <= 1'b0;
            locked            <= 1'b0;
            timeout           <= 1'b0;
        end else begin
            state             <= state_nxt;
            cyc               <= cyc_nxt;
            hi_lat            <= hi_lat_nxt;
            level             <= level_nxt;
            period_cycles     <= period_nxt;
            high_cycles       <= high_nxt;
            measurement_valid <= valid_nxt;
            locked            <= locked_nxt;
            timeout           <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_square_wave_period_detector.sv
// Bench for square_wave_period_detector: two instances (timeout limits 1000 and 200)
// checked every cycle against a timestamp-based reference model plus directed checks.
module tb_square_wave_period_detector;

    localparam int     HI_TH = 10923;
    localparam int     LO_TH = 5461;
    localparam longint MAX0  = 1000;
    localparam longint MAX1  = 200;

    logic               clk  = 1'b0;
    logic               rst  = 1'b1;
    logic               en   = 1'b0;
    logic signed [15:0] in_s = '0;

    logic        lvl0, val0, lck0, to0;
    logic [31:0] per0, hi0;
    logic        lvl1, val1, lck1, to1;
    logic [31:0] per1, hi1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    square_wave_period_detector #(.MAX_PERIOD_CYCLES(1000)) u_dut0 (
        .clk(clk), .I_RST(rst), .audio_clk_en(en), .in(in_s),
        .level(lvl0), .period_cycles(per0), .high_cycles(hi0),
        .measurement_valid(val0), .locked(lck0), .timeout(to0)
    );

    square_wave_period_detector #(.MAX_PERIOD_CYCLES(200)) u_dut1 (
        .clk(clk), .I_RST(rst), .audio_clk_en(en), .in(in_s),
        .level(lvl1), .period_cycles(per1), .high_cycles(hi1),
        .measurement_valid(val1), .locked(lck1), .timeout(to1)
    );

    logic [67:0] obs [2];
    assign obs[0] = {lvl0, val0, lck0, to0, per0, hi0};
    assign obs[1] = {lvl1, val1, lck1, to1, per1, hi1};

    // Reference model: tracks timestamps of the last rise/fall rather than counters
    longint      now = 0;
    logic        m_level [2];
    logic        m_armed [2];
    longint      t_rise  [2];
    longint      t_fall  [2];
    logic [31:0] m_per   [2];
    logic [31:0] m_high  [2];
    logic        m_valid [2];
    logic        m_locked[2];
    logic        m_to    [2];
    logic [67:0] mexp    [2];

    always @(posedge clk) begin : ref_model
        logic   nl;
        longint lim;
        for (int i = 0; i < 2; i++) begin
            lim = (i == 0) ? MAX0 : MAX1;
            if (rst) begin
                m_level[i] = 1'b0; m_armed[i] = 1'b0; m_valid[i] = 1'b0;
                m_locked[i] = 1'b0; m_to[i] = 1'b0; m_per[i] = '0; m_high[i] = '0;
                t_rise[i] = 0; t_fall[i] = 0;
            end else begin
                nl = m_level[i];
                if (en && int'(in_s) >= HI_TH) nl = 1'b1;
                else if (en && int'(in_s) <= LO_TH) nl = 1'b0;
                m_valid[i] = 1'b0;
                m_to[i]    = 1'b0;
                if (nl && !m_level[i]) begin
                    if (m_armed[i]) begin
                        m_per[i]    = 32'(now - t_rise[i]);
                        m_high[i]   = 32'(t_fall[i] - t_rise[i]);
                        m_valid[i]  = 1'b1;
                        m_locked[i] = 1'b1;
                    end
                    m_armed[i] = 1'b1;
                    t_rise[i]  = now;
                end else begin
                    if (!nl && m_level[i] && m_armed[i]) t_fall[i] = now;
                    if (m_armed[i] && (now - t_rise[i] == lim)) begin
                        m_to[i] = 1'b1; m_locked[i] = 1'b0; m_armed[i] = 1'b0;
                        m_per[i] = '0; m_high[i] = '0;
                    end
                end
                m_level[i] = nl;
            end
            mexp[i] = {m_level[i], m_valid[i], m_locked[i], m_to[i], m_per[i], m_high[i]};
        end
        now++;
    end

    // Apply inputs for one clk edge and return at the following falling edge
    task automatic drive(input logic e, input logic signed [15:0] v);
        en   = e;
        in_s = v;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 16'sd0);
        drive(1'b0, 16'sd0);
        rst = 1'b0;
    endtask

    function automatic logic signed [15:0] wave(input int c, input int per, input int hi);
        return ((c % per) < hi) ? 16'sd16384 : 16'sd0;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 16'sd20000);
        drive(1'b1, 16'sd20000);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs[k] !== 68'd0) begin
                errors++;
                $display("FAIL reset_state inst%0d: got %h expected 0", k, obs[k]);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_hysteresis();
        do_reset();
        for (int c = 0; c < 50; c++) begin
            drive(1'b1, 16'sd8000);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs[k] !== mexp[k]) begin
                    errors++;
                    $display("FAIL hyst_model inst%0d cycle %0d: got %h expected %h", k, now, obs[k], mexp[k]);
                end
            end
        end
        checks++;
        if (lvl0 !== 1'b0) begin errors++; $display("FAIL hyst_band_low: got %b expected 0", lvl0); end
        drive(1'b1, 16'sd10922);
        checks++;
        if (lvl0 !== 1'b0) begin errors++; $display("FAIL hyst_just_below_high: got %b expected 0", lvl0); end
        drive(1'b1, 16'sd11000);
        checks++;
        if (lvl0 !== 1'b1) begin errors++; $display("FAIL hyst_rise: got %b expected 1", lvl0); end
        for (int c = 0; c < 10; c++) drive(1'b1, 16'sd8000);
        checks++;
        if (lvl0 !== 1'b1) begin errors++; $display("FAIL hyst_band_high: got %b expected 1", lvl0); end
        drive(1'b0, -16'sd30000);
        checks++;
        if (lvl0 !== 1'b1) begin errors++; $display("FAIL hyst_no_strobe: got %b expected 1", lvl0); end
        drive(1'b1, 16'sd5461);
        checks++;
        if (lvl0 !== 1'b0) begin errors++; $display("FAIL hyst_low_edge: got %b expected 0", lvl0); end
        drive(1'b1, 16'sd10923);
        checks++;
        if (lvl0 !== 1'b1) begin errors++; $display("FAIL hyst_high_edge: got %b expected 1", lvl0); end
    endtask

    task automatic test_basic();
        int nval;
        int last;
        nval = 0;
        last = -1;
        do_reset();
        for (int c = 0; c < 601; c++) begin
            drive(1'b1, wave(c, 200, 100));
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs[k] !== mexp[k]) begin
                    errors++;
                    $display("FAIL basic_model inst%0d cycle %0d: got %h expected %h", k, now, obs[k], mexp[k]);
                end
            end
            if (val0) begin
                nval++;
                checks++;
                if (per0 !== 32'd200 || hi0 !== 32'd100 || lck0 !== 1'b1) begin
                    errors++;
                    $display("FAIL basic_meas: got per=%0d hi=%0d lock=%b expected 200/100/1", per0, hi0, lck0);
                end
                if (last >= 0) begin
                    checks++;
                    if (c - last != 200) begin
                        errors++;
                        $display("FAIL basic_spacing: got %0d expected 200", c - last);
                    end
                end
                last = c;
            end
        end
        checks++;
        if (nval != 3) begin errors++; $display("FAIL basic_count: got %0d expected 3", nval); end
    endtask

    task automatic test_simultaneous();
        int nval;
        int nto;
        nval = 0;
        nto  = 0;
        do_reset();
        for (int c = 0; c < 601; c++) begin
            drive(1'b1, wave(c, 200, 100));
            if (to1) nto++;
            if (val1) begin
                nval++;
                checks++;
                if (per1 !== 32'd200 || hi1 !== 32'd100) begin
                    errors++;
                    $display("FAIL simul_meas: got per=%0d hi=%0d expected 200/100", per1, hi1);
                end
            end
        end
        checks++;
        if (nval != 3 || nto != 0) begin
            errors++;
            $display("FAIL simul_counts: got valid=%0d timeout=%0d expected 3/0", nval, nto);
        end
    endtask

    task automatic test_strobed();
        int nval;
        nval = 0;
        do_reset();
        for (int s = 0; s < 301; s++) begin
            for (int q = 0; q < 4; q++) begin
                if (q == 0) drive(1'b1, ((s % 100) < 25) ? 16'sd16384 : 16'sd0);
                else drive(1'b0, 16'($urandom));
                for (int k = 0; k < 2; k++) begin
                    checks++;
                    if (obs[k] !== mexp[k]) begin
                        errors++;
                        $display("FAIL strobe_model inst%0d cycle %0d: got %h expected %h", k, now, obs[k], mexp[k]);
                    end
                end
                if (val0) begin
                    nval++;
                    checks++;
                    if (per0 !== 32'd400 || hi0 !== 32'd100) begin
                        errors++;
                        $display("FAIL strobe_meas: got per=%0d hi=%0d expected 400/100", per0, hi0);
                    end
                end
            end
        end
        checks++;
        if (nval != 3) begin errors++; $display("FAIL strobe_count: got %0d expected 3", nval); end
    endtask

    task automatic test_timeout();
        int  k;
        int  nval;
        int  first;
        bit  seen;
        do_reset();
        for (int c = 0; c < 401; c++) drive(1'b1, wave(c, 200, 100));
        checks++;
        if (lck0 !== 1'b1) begin errors++; $display("FAIL timeout_prelock: got %b expected 1", lck0); end
        k = 0;
        seen = 1'b0;
        while (!seen && k < 1200) begin
            drive(1'b1, (k < 99) ? 16'sd16384 : 16'sd0);
            k++;
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs[i] !== mexp[i]) begin
                    errors++;
                    $display("FAIL timeout_model inst%0d cycle %0d: got %h expected %h", i, now, obs[i], mexp[i]);
                end
            end
            if (to0) seen = 1'b1;
        end
        checks++;
        if (!seen || k != 1000) begin
            errors++;
            $display("FAIL timeout_delay: got seen=%b after %0d cycles expected 1000", seen, k);
        end
        checks++;
        if ({lck0, per0, hi0} !== 65'd0) begin
            errors++;
            $display("FAIL timeout_clear: got lock=%b per=%0d hi=%0d expected 0/0/0", lck0, per0, hi0);
        end
        drive(1'b1, 16'sd0);
        checks++;
        if (to0 !== 1'b0) begin errors++; $display("FAIL timeout_width: got %b expected 0", to0); end
        nval  = 0;
        first = -1;
        for (int c = 0; c < 401; c++) begin
            drive(1'b1, wave(c, 200, 100));
            if (val0) begin
                nval++;
                if (first < 0) first = c;
            end
        end
        checks++;
        if (nval != 2 || first != 200) begin
            errors++;
            $display("FAIL timeout_restart: got valids=%0d first=%0d expected 2 at 200", nval, first);
        end
    endtask

    task automatic test_reset_mid();
        int npulse;
        npulse = 0;
        do_reset();
        for (int c = 0; c < 551; c++) drive(1'b1, wave(c, 200, 100));
        checks++;
        if (lck0 !== 1'b1) begin errors++; $display("FAIL rstmid_prelock: got %b expected 1", lck0); end
        rst = 1'b1;
        drive(1'b1, 16'sd0);
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs[k] !== 68'd0) begin
                errors++;
                $display("FAIL rstmid_clear inst%0d: got %h expected 0", k, obs[k]);
            end
        end
        for (int c = 552; c <= 800; c++) begin
            drive(1'b1, wave(c, 200, 100));
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs[k] !== mexp[k]) begin
                    errors++;
                    $display("FAIL rstmid_model inst%0d cycle %0d: got %h expected %h", k, now, obs[k], mexp[k]);
                end
            end
            if (c < 800 && (val0 || to0)) npulse++;
        end
        checks++;
        if (npulse != 0) begin errors++; $display("FAIL rstmid_no_pulse: got %0d expected 0", npulse); end
        checks++;
        if (val0 !== 1'b1 || per0 !== 32'd200 || hi0 !== 32'd100) begin
            errors++;
            $display("FAIL rstmid_relock: got v=%b per=%0d hi=%0d expected 1/200/100", val0, per0, hi0);
        end
    endtask

    task automatic test_random();
        int  len;
        int  r;
        int  v;
        logic e;
        do_reset();
        for (int seg = 0; seg < 24; seg++) begin
            if (seg == 13) do_reset();
            len = int'($urandom_range(1, 320));
            for (int c = 0; c < len; c++) begin
                e = ($urandom_range(0, 3) != 0);
                r = int'($urandom_range(0, 9));
                if (r < 2) v = int'($urandom_range(LO_TH + 1, HI_TH - 1));
                else if (seg % 2 == 0) v = int'($urandom_range(HI_TH, 32767));
                else v = int'($urandom_range(0, LO_TH + 32768)) - 32768;
                drive(e, 16'(v));
                for (int k = 0; k < 2; k++) begin
                    checks++;
                    if (obs[k] !== mexp[k]) begin
                        errors++;
                        $display("FAIL random_model inst%0d cycle %0d: got %h expected %h", k, now, obs[k], mexp[k]);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_hysteresis();
        test_basic();
        test_simultaneous();
        test_strobed();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
